// File: rtl/tone_pwm_pkg.sv
// Shared types and helpers for the tone/PWM channel bank.
package tone_pwm_pkg;

    // Default counter, period and duty width in bits.
    localparam int CNT_W_DEF = 16;

    // One channel configuration word as written through the config port.
    typedef struct packed {
        logic [CNT_W_DEF-1:0] period;
        logic [CNT_W_DEF-1:0] duty;
    } ch_cfg_t;

    // Width of the channel select field; a single channel still gets one bit.
    function automatic int ch_idx_w(input int n_ch);
        if (n_ch <= 1) begin
            return 1;
        end else begin
            return $clog2(n_ch);
        end
    endfunction

endpackage

// File: rtl/tone_pwm_channel.sv
// One PWM/tone channel: free-running counter, active and shadow config,
// pending flag and registered wave output. The active config only changes
// on a wrap edge (or while the channel is stopped), so the output never glitches.
// Optional wrap pulse output when TONE_PWM_WRAP_IRQ_EN is defined.
// The shadow register holds CNT_W_DEF bits per field, so CNT_W must not exceed it.
module tone_pwm_channel
    import tone_pwm_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             wr,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_duty,
    output logic             pend,
    output logic             wave
`ifdef TONE_PWM_WRAP_IRQ_EN
    ,
    output logic             wrap_pulse
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] per_act_r;
    logic [CNT_W-1:0] duty_act_r;
    ch_cfg_t          shadow_r;
    logic             pend_r;
    logic             wave_r;
    logic             wrap_s;
    logic             apply_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Wrap detection, next counter value and the shadow-apply decision.
    always_comb begin
        wrap_s    = 1'b0;
        apply_s   = 1'b0;
        cnt_nxt_s = {CNT_W{1'b0}};
        if (ena) begin
            wrap_s = (cnt_r == per_act_r);
            if (wrap_s) begin
                cnt_nxt_s = {CNT_W{1'b0}};
            end else begin
                cnt_nxt_s = cnt_r + CNT_ONE;
            end
        end else begin
            wrap_s    = 1'b0;
            cnt_nxt_s = {CNT_W{1'b0}};
        end
        // A stopped channel has no period in flight, so a pending config lands at once.
        apply_s = pend_r && (wrap_s || !ena);
    end

    // Counter and wave output; the compare uses the config of the period in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CNT_W{1'b0}};
            wave_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            wave_r <= ena && (cnt_r < duty_act_r);
        end
    end

    // Active/shadow config and the pending flag; a write is only accepted with pend clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_act_r  <= {CNT_W{1'b0}};
            duty_act_r <= {CNT_W{1'b0}};
            shadow_r   <= '0;
            pend_r     <= 1'b0;
        end else begin
            if (apply_s) begin
                per_act_r  <= CNT_W'(shadow_r.period);
                duty_act_r <= CNT_W'(shadow_r.duty);
                pend_r     <= 1'b0;
            end
            if (wr) begin
                shadow_r.period <= CNT_W_DEF'(cfg_period);
                shadow_r.duty   <= CNT_W_DEF'(cfg_duty);
                pend_r          <= 1'b1;
            end
        end
    end

    assign pend = pend_r;
    assign wave = wave_r;

`ifdef TONE_PWM_WRAP_IRQ_EN
    logic wrap_r;

    // One-cycle pulse following each wrap edge of a running channel.
    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_r <= 1'b0;
        end else begin
            wrap_r <= wrap_s;
        end
    end

    assign wrap_pulse = wrap_r;
`endif

endmodule

// File: rtl/tone_pwm_bank.sv
// Bank of N_CH independent PWM/tone channels sharing one config write port.
// Top level only decodes the target channel and muxes back its ready.
// Define TONE_PWM_WRAP_IRQ_EN to add the per-channel wrap_pulse output.
module tone_pwm_bank
    import tone_pwm_pkg::*;
#(
    parameter int N_CH  = 4,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_valid,
    output logic                        cfg_ready,
    input  logic [ch_idx_w(N_CH)-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]            cfg_period,
    input  logic [CNT_W-1:0]            cfg_duty,
    input  logic [N_CH-1:0]             ch_ena,
    output logic [N_CH-1:0]             wave_out
`ifdef TONE_PWM_WRAP_IRQ_EN
    ,
    output logic [N_CH-1:0]             wrap_pulse
`endif
);

    localparam int CH_W = ch_idx_w(N_CH);

    logic [N_CH-1:0] pend_s;
    logic [N_CH-1:0] wr_s;
    logic            sel_pend_s;
    logic            ready_s;

    // Ready mux: an out-of-range channel selects nothing, so it is always ready (and dropped).
    always_comb begin
        sel_pend_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            sel_pend_s = sel_pend_s | (pend_s[i] & (cfg_ch == CH_W'(i)));
        end
        ready_s = ~rst & ~sel_pend_s;
    end

    // Channel decode of an accepted write.
    always_comb begin
        wr_s = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            wr_s[i] = cfg_valid & ready_s & (cfg_ch == CH_W'(i));
        end
    end

    assign cfg_ready = ready_s;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        tone_pwm_channel #(
            .CNT_W (CNT_W)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .ena        (ch_ena[g]),
            .wr         (wr_s[g]),
            .cfg_period (cfg_period),
            .cfg_duty   (cfg_duty),
            .pend       (pend_s[g]),
            .wave       (wave_out[g])
`ifdef TONE_PWM_WRAP_IRQ_EN
            ,
            .wrap_pulse (wrap_pulse[g])
`endif
        );
    end

endmodule

// File: tb/tb_tone_pwm_bank.sv
// Self-checking bench for tone_pwm_bank: directed scenarios plus randomized
// traffic, all checked cycle by cycle against a behavioural channel model.
module tb_tone_pwm_bank;

    localparam int N     = 3;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [1:0]       cfg_ch;
    logic [CNT_W-1:0] cfg_period;
    logic [CNT_W-1:0] cfg_duty;
    logic [N-1:0]     ch_ena;
    logic [N-1:0]     wave_out;
`ifdef TONE_PWM_WRAP_IRQ_EN
    logic [N-1:0]     wrap_pulse;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: position in period, active and pending config.
    int           m_pos  [N];
    int           m_per  [N];
    int           m_duty [N];
    int           m_sper [N];
    int           m_sduty[N];
    bit           m_pend [N];
    logic [N-1:0] m_wave;
    logic [N-1:0] m_wrap;

    tone_pwm_bank #(
        .N_CH  (N),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_duty   (cfg_duty),
        .ch_ena     (ch_ena),
        .wave_out   (wave_out)
`ifdef TONE_PWM_WRAP_IRQ_EN
        ,
        .wrap_pulse (wrap_pulse)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: check ready with current inputs, advance model on the edge, check outputs after.
    task automatic step(output bit acc);
        bit exp_ready;
        bit wrap;
        if (rst) exp_ready = 1'b0;
        else if (int'(cfg_ch) >= N) exp_ready = 1'b1;
        else exp_ready = !m_pend[cfg_ch];
        #1;
        check("cfg_ready", 32'(cfg_ready), 32'(exp_ready));
        acc = cfg_valid && exp_ready;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_pos[i] = 0; m_per[i] = 0; m_duty[i] = 0;
                m_sper[i] = 0; m_sduty[i] = 0; m_pend[i] = 1'b0;
                m_wave[i] = 1'b0; m_wrap[i] = 1'b0;
            end else begin
                wrap = 1'b0;
                if (ch_ena[i]) begin
                    m_wave[i] = (m_pos[i] < m_duty[i]);
                    wrap      = (m_pos[i] == m_per[i]);
                    m_pos[i]  = wrap ? 0 : m_pos[i] + 1;
                end else begin
                    m_wave[i] = 1'b0;
                    m_pos[i]  = 0;
                end
                m_wrap[i] = wrap;
                if (m_pend[i] && (wrap || !ch_ena[i])) begin
                    m_per[i]  = m_sper[i];
                    m_duty[i] = m_sduty[i];
                    m_pend[i] = 1'b0;
                end
                if (acc && int'(cfg_ch) == i) begin
                    m_sper[i]  = int'(cfg_period);
                    m_sduty[i] = int'(cfg_duty);
                    m_pend[i]  = 1'b1;
                end
            end
        end
        @(negedge clk);
        check("wave_out", 32'(wave_out), 32'(m_wave));
`ifdef TONE_PWM_WRAP_IRQ_EN
        check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
`endif
    endtask

    task automatic write_cfg(input int ch, input int p, input int d);
        bit a;
        a          = 1'b0;
        cfg_valid  = 1'b1;
        cfg_ch     = 2'(ch);
        cfg_period = 16'(p);
        cfg_duty   = 16'(d);
        for (int k = 0; k < 64 && !a; k++) step(a);
        check("wr_accept", 32'(a), 32'd1);
        cfg_valid = 1'b0;
    endtask

    task automatic wait_pos(input int ch, input int pos);
        bit a;
        for (int k = 0; k < 64 && m_pos[ch] != pos; k++) step(a);
        check("wait_pos", 32'(m_pos[ch]), 32'(pos));
    endtask

    task automatic wait_applied(input int ch);
        bit a;
        for (int k = 0; k < 64 && m_pend[ch]; k++) step(a);
        check("wait_apply", 32'(m_pend[ch]), 32'd0);
    endtask

    task automatic count_ones(input int ch, input int cycles, output int ones);
        bit a;
        ones = 0;
        for (int k = 0; k < cycles; k++) begin
            step(a);
            ones += int'(wave_out[ch]);
        end
    endtask

    initial begin
        bit        a;
        int        ones;
        logic [9:0] pat;

        rst = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0;
        cfg_period = 16'd5; cfg_duty = 16'd2; ch_ena = 3'b111;
        for (int k = 0; k < 3; k++) step(a);
        check("rst_wave", 32'(wave_out), 32'd0);
        rst = 1'b0; cfg_valid = 1'b0; ch_ena = 3'b000;
        step(a);

        // Basic PWM on ch0: P=9, D=3 -> 30 high samples out of 100.
        write_cfg(0, 9, 3);
        step(a);
        ch_ena[0] = 1'b1;
        count_ones(0, 100, ones);
        check("pwm_ones", 32'(ones), 32'd30);

        // Shadow update on ch1 while running.
        write_cfg(1, 7, 4);
        step(a);
        ch_ena[1] = 1'b1;
        wait_pos(1, 2);
        write_cfg(1, 3, 1);
        for (int k = 0; k < 10; k++) begin
            step(a);
            pat[k] = wave_out[1];
        end
        check("shadow_pat", 32'(pat), 32'(10'b1000100001));

        // Boundary cases on ch2.
        write_cfg(2, 5, 0);
        step(a);
        ch_ena[2] = 1'b1;
        count_ones(2, 20, ones);
        check("duty0_ones", 32'(ones), 32'd0);
        write_cfg(2, 9, 12);
        wait_applied(2);
        count_ones(2, 20, ones);
        check("dgtp_ones", 32'(ones), 32'd20);
        write_cfg(2, 0, 1);
        wait_applied(2);
        count_ones(2, 20, ones);
        check("p0_ones", 32'(ones), 32'd20);

        // Channel index beyond the bank: always ready, write vanishes.
        cfg_ch = 2'd3;
        step(a);
        check("drop_ready", 32'(cfg_ready), 32'd1);
        write_cfg(3, 1, 1);
        cfg_ch = 2'd0;
        step(a);

        // Disable ch0 mid-period, then re-enable from cnt=0.
        wait_pos(0, 5);
        ch_ena[0] = 1'b0;
        step(a);
        check("dis_wave", 32'(wave_out[0]), 32'd0);
        ch_ena[0] = 1'b1;
        step(a);
        check("reen_wave", 32'(wave_out[0]), 32'd1);

        // Write landing on the wrap edge waits one full old period.
        wait_pos(0, 9);
        write_cfg(0, 4, 2);
        count_ones(0, 10, ones);
        check("defer_ones", 32'(ones), 32'd3);
        step(a);
        check("defer_new", 32'(wave_out[0]), 32'd1);

`ifdef TONE_PWM_WRAP_IRQ_EN
        begin
            int pulses;
            pulses = 0;
            for (int k = 0; k < 25; k++) begin
                step(a);
                pulses += int'(wrap_pulse[0]);
            end
            check("wrap_cnt", 32'(pulses), 32'd5);
        end
`endif

        // Randomized traffic with a mid-run reset.
        for (int c = 0; c < 400; c++) begin
            int j;
            cfg_valid  = (($urandom % 4) == 0);
            cfg_ch     = 2'($urandom % 4);
            cfg_period = 16'($urandom_range(0, 12));
            cfg_duty   = 16'($urandom_range(0, 14));
            if (($urandom % 8) == 0) begin
                j = int'($urandom % N);
                ch_ena[j] = ~ch_ena[j];
            end
            rst = (c >= 200 && c < 202);
            step(a);
            if (c == 201) begin
                check("midrst_wave", 32'(wave_out), 32'd0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
